// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_ctrl
//  Description : Control FSM for a BCD mm:ss stopwatch. Turns debounced
//                start/stop, lap and clear levels into a one-cycle count
//                enable tick and a one-cycle counter clear pulse. Freezes the
//                display while in LAP. Can optionally saturate at 59:59.
//  Revision    : 1.0  initial release
// ============================================================================
module stopwatch_ctrl #(
    parameter int DIV_MAX  = 49_999_999,
    parameter bit SATURATE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_stop,
    input  logic        lap,
    input  logic        clear,
    input  logic [15:0] cntr,
    output logic        time_en,
    output logic        cnt_rst,
    output logic [15:0] disp,
    output logic [1:0]  state,
    output logic        running
);

    localparam int                 c_DIV_W   = (DIV_MAX < 1) ? 1 : $clog2(DIV_MAX + 1);
    localparam logic [c_DIV_W-1:0] c_DIV_TC  = c_DIV_W'(DIV_MAX);
    localparam logic [15:0]        c_SAT_VAL = 16'h5959;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_LAP   = 2'b11
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_DIV_W-1:0]   r_div_cnt;
    logic [c_DIV_W-1:0]   w_div_nxt;
    logic [15:0]          r_lap_val;
    logic [15:0]          w_lap_val_nxt;
    logic                 r_cnt_rst;
    logic                 w_cnt_rst_nxt;
    logic                 r_ss_q;
    logic                 r_lap_q;
    logic                 r_clr_q;

    logic                 w_ev_ss;
    logic                 w_ev_lap;
    logic                 w_ev_clr;
    logic                 w_run_any;
    logic                 w_tc;
    logic                 w_sat_hit;

    // Rising-edge events: a held button produces a single event
    assign w_ev_ss   = start_stop & ~r_ss_q;
    assign w_ev_lap  = lap        & ~r_lap_q;
    assign w_ev_clr  = clear      & ~r_clr_q;

    assign w_run_any = (r_state == S_RUN) || (r_state == S_LAP);
    assign w_tc      = (r_div_cnt == c_DIV_TC);
    // The tick that would carry 59:59 over is swallowed and the watch pauses
    assign w_sat_hit = SATURATE && (cntr == c_SAT_VAL) && w_run_any && w_tc;

    assign time_en   = w_run_any && w_tc && !w_sat_hit;
    assign cnt_rst   = r_cnt_rst;
    assign disp      = (r_state == S_LAP) ? r_lap_val : cntr;
    assign state     = r_state;
    assign running   = w_run_any;

    // Register button levels for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ss_q  <= 1'b0;
            r_lap_q <= 1'b0;
            r_clr_q <= 1'b0;
        end else begin
            r_ss_q  <= start_stop;
            r_lap_q <= lap;
            r_clr_q <= clear;
        end
    end

    // State, prescaler, lap snapshot and clear pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_div_cnt <= '0;
            r_lap_val <= '0;
            r_cnt_rst <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_div_cnt <= w_div_nxt;
            r_lap_val <= w_lap_val_nxt;
            r_cnt_rst <= w_cnt_rst_nxt;
        end
    end

    // Next-state decode; a higher-priority event masks lower ones in the
    // same cycle even when the state ignores that higher-priority event
    always_comb begin
        w_state_nxt   = r_state;
        w_div_nxt     = r_div_cnt;
        w_lap_val_nxt = r_lap_val;
        w_cnt_rst_nxt = 1'b0;

        // Prescaler: runs in RUN/LAP, keeps the partial second in PAUSE
        case (r_state)
            S_IDLE:        w_div_nxt = '0;
            S_RUN, S_LAP:  w_div_nxt = w_tc ? '0 : r_div_cnt + 1'b1;
            default:       w_div_nxt = r_div_cnt;
        endcase

        case (r_state)
            S_IDLE: begin
                if (w_ev_clr) begin
                    w_cnt_rst_nxt = 1'b1;
                end else if (w_ev_ss) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (!w_ev_clr) begin
                    if (w_ev_ss) begin
                        w_state_nxt = S_PAUSE;
                    end else if (w_ev_lap) begin
                        w_state_nxt   = S_LAP;
                        w_lap_val_nxt = cntr;
                    end
                end
            end
            S_LAP: begin
                if (!w_ev_clr) begin
                    if (w_ev_ss) begin
                        w_state_nxt = S_PAUSE;
                    end else if (w_ev_lap) begin
                        w_state_nxt = S_RUN;
                    end
                end
            end
            S_PAUSE: begin
                if (w_ev_clr) begin
                    w_state_nxt   = S_IDLE;
                    w_cnt_rst_nxt = 1'b1;
                end else if (w_ev_ss) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Saturation overrides any button activity in that cycle
        if (w_sat_hit) begin
            w_state_nxt   = S_PAUSE;
            w_div_nxt     = '0;
            w_lap_val_nxt = r_lap_val;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stopwatch_ctrl
//  Description : Self-checking bench for stopwatch_ctrl. Two instances run on
//                shared stimulus, one saturating and one wrapping, each
//                compared with a behavioural model of the stopwatch rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_stopwatch_ctrl;

    localparam int DM      = 3;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_LAP   = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_stop = 1'b0;
    logic        lap = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] cntr = 16'h0000;

    logic        te [2];
    logic        cr [2];
    logic        rn [2];
    logic [15:0] dp [2];
    logic [1:0]  st [2];

    int checks   = 0;
    int failures = 0;

    // Model state: index 0 = saturating instance, 1 = wrapping instance
    int          m_mode [2] = '{M_IDLE, M_IDLE};
    int          m_ph   [2] = '{0, 0};
    logic [15:0] m_lap  [2] = '{16'h0, 16'h0};
    bit          m_crst [2] = '{1'b0, 1'b0};
    bit          p_ss = 1'b0, p_lp = 1'b0, p_cl = 1'b0;

    always #5 clk = ~clk;

    stopwatch_ctrl #(.DIV_MAX(DM), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .start_stop(start_stop), .lap(lap), .clear(clear),
        .cntr(cntr), .time_en(te[0]), .cnt_rst(cr[0]), .disp(dp[0]),
        .state(st[0]), .running(rn[0])
    );

    stopwatch_ctrl #(.DIV_MAX(DM), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .start_stop(start_stop), .lap(lap), .clear(clear),
        .cntr(cntr), .time_en(te[1]), .cnt_rst(cr[1]), .disp(dp[1]),
        .state(st[1]), .running(rn[1])
    );

    function automatic bit m_running(int d);
        return (m_mode[d] == M_RUN) || (m_mode[d] == M_LAP);
    endfunction

    function automatic bit m_tick(int d);
        return m_running(d) && (m_ph[d] == DM) && !((d == 0) && (cntr == 16'h5959));
    endfunction

    function automatic logic [15:0] m_disp(int d);
        return (m_mode[d] == M_LAP) ? m_lap[d] : cntr;
    endfunction

    // mm:ss as a count of seconds modulo one hour
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        int t;
        int mm;
        int ss;
        t  = (v[15:12] * 600 + v[11:8] * 60 + v[7:4] * 10 + v[3:0] + 1) % 3600;
        mm = t / 60;
        ss = t % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    // Apply one clock's worth of stopwatch rules to the model
    function automatic void model_advance();
        bit ec, es, el;
        ec = clear && !p_cl;
        es = start_stop && !p_ss;
        el = lap && !p_lp;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_mode[d] = M_IDLE;
                m_ph[d]   = 0;
                m_lap[d]  = 16'h0;
                m_crst[d] = 1'b0;
            end else begin
                bit sat;
                int nm;
                int nph;
                sat = (d == 0) && m_running(d) && (m_ph[d] == DM) && (cntr == 16'h5959);
                nm  = m_mode[d];
                if (m_mode[d] == M_IDLE)  nph = 0;
                else if (m_running(d))    nph = (m_ph[d] + 1) % (DM + 1);
                else                      nph = m_ph[d];
                m_crst[d] = 1'b0;
                if (ec) begin
                    if (m_mode[d] == M_IDLE)  m_crst[d] = 1'b1;
                    if (m_mode[d] == M_PAUSE) begin nm = M_IDLE; m_crst[d] = 1'b1; end
                end else if (es) begin
                    nm = (m_running(d)) ? M_PAUSE : M_RUN;
                end else if (el) begin
                    if (m_mode[d] == M_RUN) begin nm = M_LAP; m_lap[d] = cntr; end
                    else if (m_mode[d] == M_LAP) nm = M_RUN;
                end
                if (sat) begin
                    nm  = M_PAUSE;
                    nph = 0;
                end
                m_mode[d] = nm;
                m_ph[d]   = nph;
            end
        end
        p_ss = rst ? 1'b0 : start_stop;
        p_lp = rst ? 1'b0 : lap;
        p_cl = rst ? 1'b0 : clear;
    endfunction

    // One clock: advance model, clock the DUTs, then emulate the BCD counter
    task automatic step();
        bit tk;
        bit crs;
        bit rs;
        tk  = m_tick(0);
        crs = m_crst[0];
        rs  = rst;
        model_advance();
        @(posedge clk);
        #1;
        if (rs || crs)  cntr = 16'h0000;
        else if (tk)    cntr = bcd_inc(cntr);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
        step();
        step();
        cntr = 16'h1234;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++; if (st[d] !== 2'b00) begin failures++; $display("FAIL reset_state dut%0d got=%0d exp=0", d, st[d]); end
            checks++; if (te[d] !== 1'b0) begin failures++; $display("FAIL reset_time_en dut%0d got=%0b exp=0", d, te[d]); end
            checks++; if (rn[d] !== 1'b0) begin failures++; $display("FAIL reset_running dut%0d got=%0b exp=0", d, rn[d]); end
            checks++; if (cr[d] !== 1'b0) begin failures++; $display("FAIL reset_cnt_rst dut%0d got=%0b exp=0", d, cr[d]); end
            checks++; if (dp[d] !== 16'h1234) begin failures++; $display("FAIL reset_disp dut%0d got=%h exp=1234", d, dp[d]); end
        end
        rst = 1'b0;
    endtask

    task automatic test_start_tick();
        do_reset();
        start_stop = 1'b1;
        step();
        checks++; if (st[0] !== 2'b01) begin failures++; $display("FAIL start_state got=%0d exp=1", st[0]); end
        start_stop = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            checks++;
            if (te[0] !== ((k % 4) == 0)) begin
                failures++; $display("FAIL tick_period run_cycle=%0d got=%0b exp=%0b", k, te[0], ((k % 4) == 0));
            end
            step();
        end
    endtask

    task automatic test_pause_resume();
        do_reset();
        start_stop = 1'b1; step();          // RUN, prescaler 0
        start_stop = 1'b0; step();          // prescaler 1
        start_stop = 1'b1; step();          // stop seen at 1, held value 2
        checks++; if (st[0] !== 2'b10) begin failures++; $display("FAIL pause_state got=%0d exp=2", st[0]); end
        start_stop = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++; if (te[0] !== 1'b0 || st[0] !== 2'b10) begin
                failures++; $display("FAIL pause_hold k=%0d te=%0b st=%0d exp te=0 st=2", k, te[0], st[0]);
            end
        end
        start_stop = 1'b1; step();
        checks++; if (st[0] !== 2'b01 || te[0] !== 1'b0) begin
            failures++; $display("FAIL resume_first te=%0b st=%0d exp te=0 st=1", te[0], st[0]);
        end
        start_stop = 1'b0; step();
        checks++; if (te[0] !== 1'b1) begin failures++; $display("FAIL resume_tick got=%0b exp=1", te[0]); end
    endtask

    task automatic test_lap();
        do_reset();
        start_stop = 1'b1; step();
        start_stop = 1'b0; step();
        cntr = 16'h0123;
        lap  = 1'b1; step();
        checks++; if (st[0] !== 2'b11 || dp[0] !== 16'h0123 || rn[0] !== 1'b1) begin
            failures++; $display("FAIL lap_enter st=%0d disp=%h run=%0b exp st=3 disp=0123 run=1", st[0], dp[0], rn[0]);
        end
        for (int i = 0; i < 6; i++) begin
            lap = 1'b0; step();
            cntr = 16'h0130 + 16'(i);
            #1;
            checks++; if (dp[0] !== 16'h0123 || st[0] !== 2'b11) begin
                failures++; $display("FAIL lap_freeze i=%0d disp=%h st=%0d exp disp=0123 st=3", i, dp[0], st[0]);
            end
        end
        lap = 1'b1; step();
        checks++; if (st[0] !== 2'b01 || dp[0] !== cntr) begin
            failures++; $display("FAIL lap_release st=%0d disp=%h exp st=1 disp=%h", st[0], dp[0], cntr);
        end
        lap = 1'b0; step();
        lap = 1'b1; step();
        lap = 1'b0; start_stop = 1'b1; step();
        checks++; if (st[0] !== 2'b10 || dp[0] !== cntr) begin
            failures++; $display("FAIL lap_to_pause st=%0d disp=%h exp st=2 disp=%h", st[0], dp[0], cntr);
        end
        start_stop = 1'b0;
    endtask

    task automatic test_clear();
        do_reset();
        start_stop = 1'b1; step();
        start_stop = 1'b0; step();
        clear = 1'b1; step();
        checks++; if (st[0] !== 2'b01 || cr[0] !== 1'b0) begin
            failures++; $display("FAIL clear_in_run st=%0d cnt_rst=%0b exp st=1 cnt_rst=0", st[0], cr[0]);
        end
        step();
        checks++; if (cr[0] !== 1'b0) begin failures++; $display("FAIL clear_in_run_late got=%0b exp=0", cr[0]); end
        clear = 1'b0; start_stop = 1'b1; step();
        start_stop = 1'b0; step();
        clear = 1'b1; step();
        checks++; if (st[0] !== 2'b00 || cr[0] !== 1'b1) begin
            failures++; $display("FAIL clear_in_pause st=%0d cnt_rst=%0b exp st=0 cnt_rst=1", st[0], cr[0]);
        end
        clear = 1'b0; step();
        checks++; if (cr[0] !== 1'b0 || st[0] !== 2'b00) begin
            failures++; $display("FAIL clear_pulse_width cnt_rst=%0b st=%0d exp cnt_rst=0 st=0", cr[0], st[0]);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        cntr = 16'h5959;
        start_stop = 1'b1; step();
        start_stop = 1'b0; step();
        step();
        step();
        checks++; if (te[0] !== 1'b0) begin failures++; $display("FAIL sat_tick_suppressed got=%0b exp=0", te[0]); end
        checks++; if (te[1] !== 1'b1) begin failures++; $display("FAIL wrap_tick_passes got=%0b exp=1", te[1]); end
        step();
        checks++; if (st[0] !== 2'b10 || st[1] !== 2'b01) begin
            failures++; $display("FAIL sat_state sat=%0d wrap=%0d exp sat=2 wrap=1", st[0], st[1]);
        end
        checks++; if (dp[0] !== 16'h5959) begin failures++; $display("FAIL sat_disp got=%h exp=5959", dp[0]); end
        clear = 1'b1; step();
        checks++; if (st[0] !== 2'b00 || cr[0] !== 1'b1 || cr[1] !== 1'b0) begin
            failures++; $display("FAIL sat_clear st=%0d crs=%0b crw=%0b exp st=0 crs=1 crw=0", st[0], cr[0], cr[1]);
        end
        clear = 1'b0;
    endtask

    task automatic test_priority_and_rst();
        do_reset();
        start_stop = 1'b1; step();
        start_stop = 1'b0; step();
        start_stop = 1'b1; step();
        start_stop = 1'b0; step();
        clear = 1'b1; start_stop = 1'b1; step();
        checks++; if (st[0] !== 2'b00 || cr[0] !== 1'b1) begin
            failures++; $display("FAIL clear_beats_start st=%0d cnt_rst=%0b exp st=0 cnt_rst=1", st[0], cr[0]);
        end
        clear = 1'b0; start_stop = 1'b0; step();
        start_stop = 1'b1; step();
        start_stop = 1'b0; step();
        step();
        rst = 1'b1; step();
        cntr = 16'h0456;
        #1;
        checks++; if (st[0] !== 2'b00 || te[0] !== 1'b0 || dp[0] !== 16'h0456) begin
            failures++; $display("FAIL rst_in_run st=%0d te=%0b disp=%h exp st=0 te=0 disp=0456", st[0], te[0], dp[0]);
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            int r;
            bit sat_window;
            sat_window = m_running(0) && (m_ph[0] == DM) && (cntr == 16'h5959);
            r = int'($urandom_range(0, 15));
            if (!sat_window) begin
                if (r == 0) start_stop = ~start_stop;
                if (r == 1) lap        = ~lap;
                if (r == 2) clear      = ~clear;
            end
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 99) == 0) cntr = 16'h5957;
            #1;
            step();
            for (int d = 0; d < 2; d++) begin
                checks++; if (st[d] !== 2'(m_mode[d])) begin failures++; $display("FAIL rand_state dut%0d cyc=%0d got=%0d exp=%0d", d, c, st[d], m_mode[d]); end
                checks++; if (te[d] !== m_tick(d)) begin failures++; $display("FAIL rand_time_en dut%0d cyc=%0d got=%0b exp=%0b", d, c, te[d], m_tick(d)); end
                checks++; if (cr[d] !== m_crst[d]) begin failures++; $display("FAIL rand_cnt_rst dut%0d cyc=%0d got=%0b exp=%0b", d, c, cr[d], m_crst[d]); end
                checks++; if (dp[d] !== m_disp(d)) begin failures++; $display("FAIL rand_disp dut%0d cyc=%0d got=%h exp=%h", d, c, dp[d], m_disp(d)); end
                checks++; if (rn[d] !== m_running(d)) begin failures++; $display("FAIL rand_running dut%0d cyc=%0d got=%0b exp=%0b", d, c, rn[d], m_running(d)); end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        #1;
        test_reset();
        test_start_tick();
        test_pause_resume();
        test_lap();
        test_clear();
        test_saturate();
        test_priority_and_rst();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
